// File: rtl/pt_pixel_fetch.sv
// Pulls one pixel per request from the upstream filter stage, checks its raster position
// and queues it in a small FIFO for the projective-transform stage.
`ifndef LOG_TRUNC
`define LOG_TRUNC 8
`endif
`ifndef IMAGE_WIDTH
`define IMAGE_WIDTH 640
`endif
`ifndef IMAGE_HEIGHT
`define IMAGE_HEIGHT 480
`endif

module pt_pixel_fetch #(
  parameter int PIX_W = `LOG_TRUNC,
  parameter int IMG_W = `IMAGE_WIDTH,
  parameter int IMG_H = `IMAGE_HEIGHT,
  parameter int DEPTH = 8,
  parameter int TMO   = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             frame_flag,
  input  logic             enable,
  output logic             request,
  input  logic [PIX_W-1:0] pixel,
  input  logic [9:0]       x_in,
  input  logic [8:0]       y_in,
  input  logic             pixel_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic [9:0]       out_x,
  output logic [8:0]       out_y,
  output logic             frame_done,
  output logic             busy,
  output logic             err_timeout,
  output logic             err_coord
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TMO + 1);
  localparam int EW = PIX_W + 19;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t        state;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [9:0]    ex;
  logic [8:0]    ey;
  logic [TW-1:0] tmo_cnt;
  logic          push, pop, last;

  // A new frame flushes everything, so it overrides both push and pop.
  assign push      = (state == WAIT) && pixel_flag && !frame_flag;
  assign pop       = out_valid && out_ready && !frame_flag;
  assign out_valid = (count != '0);
  assign busy      = (state != IDLE);
  assign last      = (ex == 10'(IMG_W - 1)) && (ey == 9'(IMG_H - 1));

  // Only one request is ever outstanding, so a free slot now is a slot reserved for its reply.
  assign request = (state == REQ) && enable && !frame_flag && (count < CW'(DEPTH));

  assign {out_pixel, out_x, out_y} = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {pixel, x_in, y_in};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ex          <= '0;
      ey          <= '0;
      tmo_cnt     <= '0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
      err_coord   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame_flag) begin
        state   <= enable ? REQ : IDLE;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        ex      <= '0;
        ey      <= '0;
        tmo_cnt <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase

        case (state)
          IDLE: ;
          REQ: begin
            if (request) begin
              state   <= WAIT;
              tmo_cnt <= '0;
            end
          end
          WAIT: begin
            if (pixel_flag) begin
              if (x_in != ex || y_in != ey) err_coord <= 1'b1;
              if (ex == 10'(IMG_W - 1)) begin
                ex <= '0;
                ey <= ey + 1'b1;
              end else begin
                ex <= ex + 1'b1;
              end
              if (last) begin
                state      <= DONE;
                frame_done <= 1'b1;
              end else begin
                state <= REQ;
              end
            end else if (tmo_cnt != TW'(TMO)) begin
              // Counter parks at TMO; the flag is raised but we keep waiting.
              tmo_cnt <= tmo_cnt + 1'b1;
              if (tmo_cnt == TW'(TMO - 1)) err_timeout <= 1'b1;
            end
          end
          DONE: begin
            if (count == '0) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pt_pixel_fetch.sv
// Self-checking bench for pt_pixel_fetch: a scripted pixel source, a queue of expected
// FIFO outputs, and directed checks of flush, backpressure, error and reset behaviour.
module tb_pt_pixel_fetch;
  localparam int PIX_W = 8;
  localparam int IMG_W = 8;
  localparam int IMG_H = 3;
  localparam int DEPTH = 8;
  localparam int TMO   = 255;

  logic             clock = 1'b0;
  logic             reset, frame_flag, enable, request, pixel_flag;
  logic             out_valid, out_ready, frame_done, busy, err_timeout, err_coord;
  logic [PIX_W-1:0] pixel, out_pixel;
  logic [9:0]       x_in, out_x;
  logic [8:0]       y_in, out_y;

  int  ntests = 0, nfail = 0, nreq = 0, nout = 0, ndone = 0;
  bit  saw_req = 1'b0;
  logic [26:0] exp_q[$];

  always #5 clock = ~clock;

  pt_pixel_fetch #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .DEPTH(DEPTH), .TMO(TMO)) dut (
    .clock(clock), .reset(reset), .frame_flag(frame_flag), .enable(enable), .request(request),
    .pixel(pixel), .x_in(x_in), .y_in(y_in), .pixel_flag(pixel_flag),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel), .out_x(out_x),
    .out_y(out_y), .frame_done(frame_done), .busy(busy), .err_timeout(err_timeout),
    .err_coord(err_coord)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: sample outputs mid-cycle, then land just after the next rising edge.
  task automatic tick();
    logic [26:0] e;
    @(negedge clock);
    saw_req = request;
    if (request) nreq++;
    if (frame_done) ndone++;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("out_unexpected", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        nout++;
        check("out_data", 32'({out_pixel, out_x, out_y}), 32'(e));
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic wait_req(input int budget, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < budget) begin
      tick();
      ok = saw_req;
      n++;
    end
  endtask

  // Reply three cycles after the request seen in the previous tick.
  task automatic send(input logic [9:0] x, input logic [8:0] y);
    logic [7:0] p;
    p = 8'($urandom_range(0, 255));
    repeat (2) tick();
    pixel = p; x_in = x; y_in = y; pixel_flag = 1'b1;
    exp_q.push_back({p, x, y});
    tick();
    pixel_flag = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [9:0] x, input logic [8:0] y);
    bit ok;
    wait_req(20, ok);
    check(tag, 32'(ok), 32'd1);
    if (ok) send(x, y);
  endtask

  task automatic start_frame(input logic en);
    frame_flag = 1'b1; enable = en;
    tick();
    frame_flag = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_request"}, 32'(request), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
    check({tag, "_err_coord"}, 32'(err_coord), 32'd0);
    check({tag, "_out_data"}, 32'({out_pixel, out_x, out_y}), 32'd0);
  endtask

  initial begin
    bit ok;
    int base, served;
    reset = 1'b1; frame_flag = 1'b0; enable = 1'b0; pixel_flag = 1'b0;
    pixel = '0; x_in = '0; y_in = '0; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // frame_flag with enable low stays idle
    start_frame(1'b0);
    base = nreq;
    repeat (5) tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_noreq", 32'(nreq - base), 32'd0);

    // full frame, source always answers correctly
    nout = 0; ndone = 0;
    start_frame(1'b1);
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++)
        fetch("t1_req", 10'(x), 9'(y));
    drain(50);
    repeat (3) tick();
    check("t1_pixels", 32'(nout), 32'(IMG_W * IMG_H));
    check("t1_frame_done", 32'(ndone), 32'd1);
    check("t1_err_coord", 32'(err_coord), 32'd0);
    check("t1_err_timeout", 32'(err_timeout), 32'd0);
    check("t1_idle", 32'(busy), 32'd0);

    // backpressure: FIFO fills to DEPTH then fetching stalls
    out_ready = 1'b0;
    start_frame(1'b1);
    base = nreq; served = 0;
    for (int i = 0; i < 12; i++) begin
      wait_req(20, ok);
      if (!ok) break;
      send(10'(served), 9'd0);
      served++;
    end
    check("t2_reqs", 32'(nreq - base), 32'(DEPTH));
    check("t2_served", 32'(served), 32'(DEPTH));
    check("t2_out_valid", 32'(out_valid), 32'd1);
    nout = 0;
    out_ready = 1'b1;
    wait_req(20, ok);
    check("t2_resume", 32'(ok), 32'd1);
    send(10'd0, 9'd1);
    drain(30);
    check("t2_drained", 32'(nout), 32'(DEPTH + 1));

    // frame_flag with 3 queued entries and a coincident pixel
    out_ready = 1'b0;
    start_frame(1'b1);
    for (int x = 0; x < 3; x++) fetch("t3_req", 10'(x), 9'd0);
    wait_req(20, ok);
    check("t3_req4", 32'(ok), 32'd1);
    repeat (2) tick();
    frame_flag = 1'b1; enable = 1'b1;
    pixel_flag = 1'b1; pixel = 8'hAA; x_in = 10'd3; y_in = 9'd0;
    tick();
    frame_flag = 1'b0; pixel_flag = 1'b0;
    exp_q.delete();
    check("t3_flush_valid", 32'(out_valid), 32'd0);
    wait_req(2, ok);
    check("t3_rereq", 32'(ok), 32'd1);
    out_ready = 1'b1;
    nout = 0;
    if (ok) send(10'd0, 9'd0);
    drain(10);
    check("t3_out", 32'(nout), 32'd1);
    check("t3_coord_reset", 32'(err_coord), 32'd0);

    // source returns x=5 where x=4 is expected
    start_frame(1'b1);
    nout = 0;
    for (int x = 0; x < 7; x++) begin
      if (x == 4) check("t4_pre_err", 32'(err_coord), 32'd0);
      fetch("t4_req", (x == 4) ? 10'd5 : 10'(x), 9'd0);
    end
    check("t4_err_coord", 32'(err_coord), 32'd1);
    drain(10);
    check("t4_out", 32'(nout), 32'd7);
    start_frame(1'b1);
    check("t4_sticky", 32'(err_coord), 32'd1);

    // source never answers
    wait_req(20, ok);
    check("t5_req", 32'(ok), 32'd1);
    repeat (TMO - 1) tick();
    check("t5_before_tmo", 32'(err_timeout), 32'd0);
    tick();
    check("t5_tmo", 32'(err_timeout), 32'd1);
    base = nreq;
    repeat (40) tick();
    check("t5_no_rereq", 32'(nreq - base), 32'd0);
    check("t5_busy", 32'(busy), 32'd1);

    // reset during WAIT, then a stray pixel
    reset = 1'b1;
    #1;
    check_all_zero("t6_reset");
    tick();
    reset = 1'b0;
    pixel_flag = 1'b1; pixel = 8'h55; x_in = 10'd0; y_in = 9'd0;
    tick();
    pixel_flag = 1'b0;
    check_all_zero("t6_after");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/pt_pixel_fetch.md
PT_PIXEL_FETCH -- requirements
Module: pt_pixel_fetch

Interface
REQ-001 Parameters SHALL be: PIX_W, default `LOG_TRUNC, returned pixel width; IMG_W, default `IMAGE_WIDTH, pixels per line; IMG_H, default `IMAGE_HEIGHT, lines per frame; DEPTH, default 8, output FIFO entries (power of 2); TMO, default 255, wait-timeout cycles.
REQ-002 Ports SHALL be, in order:
- clock  in  1  system clock; all state on its rising edge
- reset  in  1  asynchronous, active-high reset
- frame_flag  in  1  one-cycle pulse marking start of a new frame
- enable  in  1  allow fetching
- request  out  1  one-cycle pulse asking the upstream filter stage for the next pixel
- pixel  in  PIX_W  returned pixel
- x_in  in  10  returned pixel column
- y_in  in  9  returned pixel row
- pixel_flag  in  1  one-cycle pulse: pixel/x_in/y_in valid
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream (projective transform) accepts head
- out_pixel  out  PIX_W  head pixel
- out_x  out  10  head column
- out_y  out  9  head row
- frame_done  out  1  one-cycle pulse after last pixel of frame pushed
- busy  out  1  high when state is not IDLE
- err_timeout  out  1  sticky: wait exceeded TMO
- err_coord  out  1  sticky: returned coordinate mismatched expected

Function
REQ-003 State machine SHALL have states IDLE, REQ, WAIT, DONE.
REQ-004 IDLE -> REQ on frame_flag with enable=1; otherwise IDLE holds.
REQ-005 In REQ, request SHALL pulse for exactly one cycle when enable=1 and (fifo_count + 1) <= DEPTH, then go to WAIT; otherwise REQ holds with request=0.
REQ-006 At most one request SHALL be outstanding; request never asserts in WAIT, DONE or IDLE.
REQ-007 In WAIT, pixel_flag SHALL push {pixel,x_in,y_in} into the FIFO and advance expected (ex,ey): ex+1, wrapping to 0 with ey+1 at ex=IMG_W-1.
REQ-008 After the push of (IMG_W-1, IMG_H-1), state SHALL go to DONE and frame_done SHALL pulse the following cycle; otherwise WAIT -> REQ.
REQ-009 DONE -> IDLE when the FIFO is empty.
REQ-010 On each push, err_coord SHALL set if x_in!=ex or y_in!=ey; data is still pushed.
REQ-011 WAIT SHALL count cycles; on reaching TMO without pixel_flag, err_timeout sets and state remains WAIT (no re-request).
REQ-012 Push-to-output latency SHALL be 1 cycle: pixel_flag at cycle t gives out_valid=1 at t+1 when FIFO was empty.
REQ-013 Pop SHALL occur when out_valid & out_ready; out_ready while empty SHALL be ignored; simultaneous push and pop keep count unchanged.
REQ-014 The FIFO SHALL never overflow; REQ-005 reservation guarantees space, and the output order equals arrival order.
REQ-015 frame_flag in any state SHALL flush the FIFO, clear (ex,ey) and the timeout counter, and enter REQ (enable=1) or IDLE (enable=0); errors are not cleared.
REQ-016 frame_flag coincident with pixel_flag: frame_flag wins, the pixel is dropped.
REQ-017 enable low SHALL only block new requests; an outstanding WAIT completes normally.
REQ-018 Coordinate counters SHALL be 10 and 9 bits, unsigned, no saturation.

Reset
REQ-019 Reset SHALL force state IDLE, FIFO empty, ex=ey=0, counters 0, and request, out_valid, frame_done, busy, err_timeout, err_coord all 0; out_pixel/out_x/out_y 0.
REQ-020 Reset asserted mid-frame SHALL take effect immediately, discarding the outstanding request; a later pixel_flag in IDLE is ignored.

Verification
REQ-021 frame_flag, enable=1, source replies 3 cycles after each request with correct coords, out_ready=1 -> IMG_W*IMG_H pixels out in raster order, one frame_done, no errors.
REQ-022 out_ready=0 throughout, DEPTH=8 -> exactly 8 requests issued, then request stays 0; raising out_ready resumes fetching.
REQ-023 Source returns x_in=5 when ex=4 -> err_coord=1 sticky, pixel still output.
REQ-024 Source never answers -> err_timeout=1 after 255 WAIT cycles, no second request.
REQ-025 frame_flag with 3 entries in FIFO and coincident pixel_flag -> out_valid=0 next cycle, ex=ey=0, next request within 2 cycles.
REQ-026 Reset pulse during WAIT then pixel_flag -> all outputs 0, state IDLE, no push.
